// File: rtl/div_clk_select_pkg.sv
// Shared state encoding, source codes and source mux helper for the divided-clock selector.
package div_clk_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ALIGN = 2'd3
  } state_t;

  localparam logic [1:0] SEL_DIV4  = 2'd0;
  localparam logic [1:0] SEL_DIV8  = 2'd1;
  localparam logic [1:0] SEL_DIV80 = 2'd2;
  localparam logic [1:0] SEL_OFF   = 2'd3;

  function automatic logic src_of(input logic [1:0] code, input logic d4,
                                  input logic d8, input logic d80);
    logic v;
    v = 1'b0;
    case (code)
      SEL_DIV4:  v = d4;
      SEL_DIV8:  v = d8;
      SEL_DIV80: v = d80;
      default:   v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/div_clk_select_edge_counter.sv
// Rising-edge detector on the selector output plus a saturating edge counter with sync clear.
module div_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             level_d,
  input  logic             level_q,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  logic rise;
  assign rise = level_d & ~level_q;

  // Clear wins over a coincident rise: that rise belongs to the old source.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick <= 1'b0;
      cnt  <= '0;
    end else begin
      tick <= rise;
      if (clear)
        cnt <= '0;
      else if (rise && (cnt != '1))
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/div_clk_select.sv
// Glitch-free selector between the divider's /4, /8 and /80 outputs with handshake and edge count.
module div_clk_select
  import div_clk_select_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div4_in,
  input  logic             div8_in,
  input  logic             div80_in,
  input  logic             sel_valid,
  input  logic [1:0]       sel,
  output logic             sel_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [1:0]       active_sel,
  output logic             switching,
  output logic [CNT_W-1:0] edge_cnt,
  inout  wire              VDD,
  inout  wire              VSS
);

  state_t     state, state_d;
  logic [1:0] cur, cur_d;
  logic [1:0] nxt, nxt_d;
  logic       clk_out_d;
  logic       accept, changes;
  logic       src_cur, src_nxt;
  logic       unused_pwr;

  assign unused_pwr = VDD ^ VSS;

  assign sel_ready  = (state == ST_IDLE) || (state == ST_RUN);
  assign switching  = (state == ST_DRAIN) || (state == ST_ALIGN);
  assign active_sel = cur;
  assign accept     = sel_valid && sel_ready;
  // cur is SEL_OFF in IDLE, so this also covers the IDLE no-op on sel = off.
  assign changes    = accept && (sel != cur);

  assign src_cur = src_of(cur, div4_in, div8_in, div80_in);
  assign src_nxt = src_of(nxt, div4_in, div8_in, div80_in);

  // ALIGN watches nxt rather than cur so the IDLE entry path (cur still off)
  // aligns to the new source; after DRAIN the two are already equal.
  always_comb begin
    state_d   = state;
    cur_d     = cur;
    nxt_d     = nxt;
    clk_out_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (changes) begin
          nxt_d   = sel;
          state_d = ST_ALIGN;
        end
      end
      ST_RUN: begin
        clk_out_d = src_cur;
        if (changes) begin
          nxt_d   = sel;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (src_cur) begin
          clk_out_d = 1'b1;
        end else begin
          cur_d   = nxt;
          state_d = (nxt == SEL_OFF) ? ST_IDLE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (!src_nxt) begin
          cur_d   = nxt;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cur     <= SEL_OFF;
      nxt     <= SEL_OFF;
      clk_out <= 1'b0;
    end else begin
      state   <= state_d;
      cur     <= cur_d;
      nxt     <= nxt_d;
      clk_out <= clk_out_d;
    end
  end

  div_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk    (clk),
    .reset  (reset),
    .level_d(clk_out_d),
    .level_q(clk_out),
    .clear  (changes),
    .tick   (tick),
    .cnt    (edge_cnt)
  );

endmodule

// File: tb/tb_div_clk_select.sv
// Randomized and directed bench for div_clk_select against a behavioural switching model.
module tb_div_clk_select;

  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             div4_in, div8_in, div80_in;
  logic             sel_valid;
  logic [1:0]       sel;
  logic             sel_ready, clk_out, tick, switching;
  logic [1:0]       active_sel;
  logic [CNT_W-1:0] edge_cnt;
  wire              vdd, vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 clk = ~clk;

  div_clk_select #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .div4_in   (div4_in),
    .div8_in   (div8_in),
    .div80_in  (div80_in),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .active_sel(active_sel),
    .switching (switching),
    .edge_cnt  (edge_cnt),
    .VDD       (vdd),
    .VSS       (vss)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Free-running divider reference: phase counter n.
  int n = 0;
  task automatic drive_div();
    div4_in  = (n % 4) < 2;
    div8_in  = (n % 8) < 4;
    div80_in = (n % 80) < 40;
  endtask

  // Model: which activity is in progress, plus source bookkeeping.
  bit m_run = 0, m_drain = 0, m_align = 0;
  int m_cur = 3, m_nxt = 3;
  bit m_out = 0, m_tick = 0;
  int m_cnt = 0;
  int hi_len = 0;

  function automatic bit srcval(input int code);
    if (code == 0) return div4_in;
    if (code == 1) return div8_in;
    if (code == 2) return div80_in;
    return 1'b0;
  endfunction

  function automatic bit in_mode(input int which);
    case (which)
      0: return m_run;
      1: return m_drain;
      2: return m_align;
      default: return !m_run && !m_drain && !m_align;
    endcase
  endfunction

  task automatic model_edge();
    bit busy, acc, s_cur, s_nxt, nout;
    if (!reset) begin
      m_run = 0; m_drain = 0; m_align = 0;
      m_cur = 3; m_nxt = 3; m_out = 0; m_tick = 0; m_cnt = 0;
      return;
    end
    busy  = m_drain || m_align;
    acc   = sel_valid && !busy;
    s_cur = srcval(m_cur);
    s_nxt = srcval(m_nxt);
    nout  = (m_run || m_drain) ? s_cur : 1'b0;
    m_tick = nout && !m_out;
    m_out  = nout;
    if (acc && (int'(sel) != m_cur)) m_cnt = 0;
    else if (m_tick && m_cnt < CMAX) m_cnt++;
    if (m_drain) begin
      if (!s_cur) begin
        m_drain = 0;
        m_cur   = m_nxt;
        if (m_nxt != 3) m_align = 1;
      end
    end else if (m_align) begin
      if (!s_nxt) begin
        m_align = 0;
        m_run   = 1;
        m_cur   = m_nxt;
      end
    end else if (acc && (int'(sel) != m_cur)) begin
      m_nxt = int'(sel);
      if (m_run) begin m_run = 0; m_drain = 1; end
      else m_align = 1;
    end
  endtask

  task automatic step();
    bit rst_at_edge;
    rst_at_edge = reset;
    model_edge();
    @(posedge clk);
    #1;
    check("clk_out", 32'(clk_out), 32'(m_out));
    check("tick", 32'(tick), 32'(m_tick));
    check("active_sel", 32'(active_sel), m_cur);
    check("switching", 32'(switching), 32'(m_drain || m_align));
    check("sel_ready", 32'(sel_ready), 32'(!(m_drain || m_align)));
    check("edge_cnt", 32'(edge_cnt), m_cnt);
    // Every completed high phase must be a whole source high phase.
    if (!rst_at_edge) hi_len = 0;
    else if (clk_out) hi_len++;
    else if (hi_len > 0) begin
      check("hi_phase_len", 32'(hi_len == 2 || hi_len == 4 || hi_len == 40), 1);
      hi_len = 0;
    end
    n++;
    drive_div();
  endtask

  task automatic run_until(input int which, input int budget, input string tag);
    int k = 0;
    while (!in_mode(which) && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(in_mode(which)), 1);
  endtask

  task automatic request(input logic [1:0] s);
    sel_valid = 1'b1;
    sel       = s;
    step();
    sel_valid = 1'b0;
  endtask

  initial begin
    int ticks, highs, seen_sw, k;
    reset = 1'b0; sel_valid = 1'b0; sel = 2'd0;
    drive_div();
    repeat (3) step();
    reset = 1'b1;
    step();

    // /8 from IDLE, then 80 RUN cycles give exactly 10 edges.
    request(2'd1);
    run_until(0, 20, "wait_run8");
    ticks = 0;
    for (int i = 0; i < 80; i++) begin step(); ticks += int'(tick); end
    check("ticks_80", ticks, 10);
    check("cnt_80", 32'(edge_cnt), 10);

    // /8 -> /4 requested mid high phase.
    k = 0;
    while ((n % 8) != 1 && k < 16) begin step(); k++; end
    request(2'd0);
    check("drain_switching", 32'(switching), 1);
    check("drain_clk_high", 32'(clk_out), 1);
    run_until(0, 20, "wait_run4");
    repeat (20) step();
    check("now_div4", 32'(active_sel), 0);

    // /4 -> off: stays low for 200 cycles.
    request(2'd3);
    run_until(3, 10, "wait_idle");
    highs = 0;
    for (int i = 0; i < 200; i++) begin step(); highs += int'(clk_out); end
    check("off_highs", highs, 0);
    check("off_ready", 32'(sel_ready), 1);

    // /80 then same-source request is a no-op.
    request(2'd2);
    run_until(0, 90, "wait_run80");
    repeat (100) step();
    request(2'd2);
    seen_sw = 0;
    for (int i = 0; i < 100; i++) begin step(); seen_sw |= int'(switching); end
    check("noop_switching", seen_sw, 0);
    check("noop_cnt_kept", 32'(edge_cnt != 0), 1);

    // Request during ALIGN is ignored; pending switch to /4 completes.
    request(2'd0);
    run_until(2, 90, "wait_align");
    request(2'd1);
    run_until(0, 10, "wait_run_after_align");
    repeat (10) step();
    check("align_ignore", 32'(active_sel), 0);

    // Reset in the middle of DRAIN.
    k = 0;
    while ((n % 4) != 0 && k < 8) begin step(); k++; end
    request(2'd2);
    run_until(1, 5, "wait_drain");
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_active", 32'(active_sel), 3);
    check("rst_cnt", 32'(edge_cnt), 0);
    check("rst_ready", 32'(sel_ready), 1);

    // Saturation of the 4-bit counter.
    request(2'd0);
    run_until(0, 10, "wait_run_sat");
    repeat (80) step();
    check("cnt_sat", 32'(edge_cnt), 15);

    // Random requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      sel_valid = ($urandom_range(0, 7) == 0);
      sel       = 2'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
